// File: rtl/rx_pkt_gen_rd_ctrl_if.sv
// rx_pkt_gen_rd_ctrl_if: DRAM port B read bus plus the framed RX stream toward the LMAC
interface rx_pkt_gen_rd_ctrl_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 256
);
  logic [ADDR_WIDTH-1:0] mem_addr_b;
  logic                  mem_en_b;
  logic                  mem_we_b;
  logic [DATA_WIDTH-1:0] mem_dout_b;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_sop;
  logic                  rx_eop;
  logic [4:0]            rx_mod;
  logic                  rx_ready;
  modport master (
    output mem_addr_b, mem_en_b, mem_we_b, rx_data, rx_valid, rx_sop, rx_eop, rx_mod,
    input  mem_dout_b, rx_ready
  );
  modport slave (
    input  mem_addr_b, mem_en_b, mem_we_b, rx_data, rx_valid, rx_sop, rx_eop, rx_mod,
    output mem_dout_b, rx_ready
  );
endinterface

// File: rtl/rx_pkt_gen_rd_ctrl.sv
// rx_pkt_gen_rd_ctrl: walks a packet list in DRAM port B and emits a framed 256-bit RX stream
// Build option RX_PKT_GEN_LOOP_EN: an end-of-list header reloads base_addr and the run continues until pkt_cnt is reached
module rx_pkt_gen_rd_ctrl #(
  parameter int ADDR_WIDTH    = 11,
  parameter int DATA_WIDTH    = 256,
  parameter int RD_LAT        = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_PKT_BYTES = 9600,
  parameter int IFG_CYCLES    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           pkt_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  err_len,
  rx_pkt_gen_rd_ctrl_if.master  bus
);
`ifdef RX_PKT_GEN_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, HDR_RD, HDR_WAIT, PAY, IFG, FIN} state_t;
  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] addr_q, base_q;
  logic [15:0]           cnt_q, sent_q, words_left, hdr_len;
  logic [4:0]            mod_q;
  logic                  first_q;
  logic [7:0]            ifg_q, in_flight;

  logic [RD_LAT-1:0]     p_vld, p_hdr, p_sop, p_eop;
  logic [4:0]            p_mod [RD_LAT];

  logic [DATA_WIDTH-1:0] f_data [FIFO_DEPTH];
  logic [4:0]            f_mod [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] f_sop, f_eop;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         f_cnt;

  logic hdr_ret, push, pop, credit, drained, last_wd, ifg_done, pay_rd;

  // payload reads still travelling through the DRAM pipeline; headers never occupy FIFO space
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + 8'(p_vld[i] & ~p_hdr[i]);
  end

  assign hdr_ret  = p_vld[RD_LAT-1] & p_hdr[RD_LAT-1];
  assign push     = p_vld[RD_LAT-1] & ~p_hdr[RD_LAT-1];
  assign hdr_len  = bus.mem_dout_b[15:0];
  assign credit   = (in_flight + 8'(f_cnt)) < 8'(FIFO_DEPTH);
  assign drained  = (in_flight == '0) && (f_cnt == '0);
  assign last_wd  = words_left == 16'd1;
  assign ifg_done = 32'(ifg_q) + 32'd1 >= 32'(IFG_CYCLES);
  assign pay_rd   = (state == PAY) && credit;

  assign busy            = state != IDLE;
  assign bus.mem_en_b    = (state == HDR_RD) || pay_rd;
  assign bus.mem_addr_b  = addr_q;
  assign bus.mem_we_b    = 1'b0;
  assign bus.rx_valid    = f_cnt != '0;
  assign pop             = bus.rx_valid & bus.rx_ready;
  assign bus.rx_data     = bus.rx_valid ? f_data[rd_ptr] : '0;
  assign bus.rx_sop      = bus.rx_valid & f_sop[rd_ptr];
  assign bus.rx_eop      = bus.rx_valid & f_eop[rd_ptr];
  assign bus.rx_mod      = bus.rx_valid ? f_mod[rd_ptr] : 5'd0;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end

  // next state: header fetch, credit-paced payload, inter-frame gap, drain and finish
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? HDR_RD : IDLE;
      HDR_RD:   state_nx = HDR_WAIT;
      HDR_WAIT: state_nx = !hdr_ret ? HDR_WAIT :
                           (hdr_len == '0) ? (LOOP_EN ? HDR_RD : FIN) :
                           (hdr_len > 16'(MAX_PKT_BYTES)) ? FIN : PAY;
      PAY:      state_nx = (pay_rd && last_wd) ? IFG : PAY;
      IFG:      state_nx = !(drained && ifg_done) ? IFG :
                           ((cnt_q != '0) && (sent_q == cnt_q)) ? FIN : HDR_RD;
      FIN:      state_nx = drained ? IDLE : FIN;
      default:  state_nx = IDLE;
    endcase
  end

  // run context: address walk, packet length, word and packet counters, sticky error, done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      sent_q     <= '0;
      words_left <= '0;
      mod_q      <= '0;
      first_q    <= 1'b0;
      ifg_q      <= '0;
      err_len    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done  <= (state == FIN) && drained;
      ifg_q <= ((state == IFG) && drained) ? ifg_q + 8'd1 : 8'd0;
      if (bus.mem_en_b) addr_q <= addr_q + ADDR_WIDTH'(1);
      if ((state == IDLE) && start) begin
        addr_q  <= base_addr;
        base_q  <= base_addr;
        cnt_q   <= pkt_cnt;
        sent_q  <= '0;
        err_len <= 1'b0;
      end
      if ((state == HDR_WAIT) && hdr_ret) begin
        words_left <= 16'((17'(hdr_len) + 17'd31) >> 5);
        mod_q      <= hdr_len[4:0];
        first_q    <= 1'b1;
        if (hdr_len > 16'(MAX_PKT_BYTES)) err_len <= 1'b1;
        if (LOOP_EN && (hdr_len == '0)) addr_q <= base_q;
      end
      if (pay_rd) begin
        words_left <= words_left - 16'd1;
        first_q    <= 1'b0;
        if (last_wd) sent_q <= sent_q + 16'd1;
      end
    end
  end

  // read-tag pipeline matched to the DRAM latency; a word returns when its tag reaches the last stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_vld <= '0;
      p_hdr <= '0;
      p_sop <= '0;
      p_eop <= '0;
      for (int i = 0; i < RD_LAT; i++) p_mod[i] <= '0;
    end else begin
      p_vld[0] <= bus.mem_en_b;
      p_hdr[0] <= state == HDR_RD;
      p_sop[0] <= first_q;
      p_eop[0] <= last_wd;
      p_mod[0] <= last_wd ? mod_q : 5'd0;
      for (int i = 1; i < RD_LAT; i++) begin
        p_vld[i] <= p_vld[i-1];
        p_hdr[i] <= p_hdr[i-1];
        p_sop[i] <= p_sop[i-1];
        p_eop[i] <= p_eop[i-1];
        p_mod[i] <= p_mod[i-1];
      end
    end
  end

  // output FIFO pointers and fill; reset flushes it so rx_valid drops immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      f_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      f_cnt <= f_cnt + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; every returned payload word is accepted since the credit rule bounds the fill
  always_ff @(posedge clk) begin
    if (push) begin
      f_data[wr_ptr] <= bus.mem_dout_b;
      f_sop[wr_ptr]  <= p_sop[RD_LAT-1];
      f_eop[wr_ptr]  <= p_eop[RD_LAT-1];
      f_mod[wr_ptr]  <= p_mod[RD_LAT-1];
    end
  end
endmodule

// File: tb/tb_rx_pkt_gen_rd_ctrl.sv
// tb_rx_pkt_gen_rd_ctrl: scoreboard bench for the RX packet generator read sequencer
`timescale 1ns/1ps
module tb_rx_pkt_gen_rd_ctrl;
  localparam int AW = 11;
  localparam int DW = 256;
  localparam int FD = 4;
  localparam int MAXB = 9600;
`ifdef RX_PKT_GEN_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [4:0]    mod;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   pkt_cnt = '0;
  logic          busy, done, err_len;
  logic          rdy = 1'b1;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] r1, r2;
  beat_t         sb[$];
  logic [AW-1:0] rd_addrs[$];
  int            n_cmp = 0, n_err = 0, n_pop = 0, max_fill = 0;
  logic          stall = 1'b0;
  beat_t         hold, got, exp_b;

  always #5 clk = ~clk;

  rx_pkt_gen_rd_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  rx_pkt_gen_rd_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .pkt_cnt(pkt_cnt),
    .busy(busy), .done(done), .err_len(err_len), .bus(bus)
  );

  // two-cycle DRAM port B model
  always @(posedge clk) begin
    if (bus.mem_en_b) r1 <= mem[bus.mem_addr_b];
    r2 <= r1;
  end
  assign bus.mem_dout_b = r2;
  assign bus.rx_ready   = rdy;

  // stream monitor: pops the scoreboard on each transfer and checks stalled words hold
  always @(negedge clk) begin
    if (reset) begin
      stall = 1'b0;
    end else begin
      if (int'(dut.f_cnt) > max_fill) max_fill = int'(dut.f_cnt);
      if (bus.mem_en_b) rd_addrs.push_back(bus.mem_addr_b);
      got = {bus.rx_data, bus.rx_sop, bus.rx_eop, bus.rx_mod};
      if (stall) begin
        n_cmp++;
        if (!bus.rx_valid || got !== hold) begin
          n_err++;
          $display("FAIL hold: got valid=%b beat=%h required valid=1 beat=%h", bus.rx_valid, got, hold);
        end
      end
      if (bus.rx_valid && bus.rx_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_word: got beat=%h required no transfer", got);
        end else begin
          exp_b = sb.pop_front();
          n_pop++;
          if (got !== exp_b) begin
            n_err++;
            $display("FAIL stream_word: got %h required %h", got, exp_b);
          end
        end
      end
      stall = bus.rx_valid && !bus.rx_ready;
      hold  = got;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // writes one header plus payload into the DRAM model and optionally queues the expected beats
  task automatic put_pkt(input logic [AW-1:0] a_in, input int len, input bit queue_it, output logic [AW-1:0] a_out);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int nw;
    a = a_in;
    mem[a] = {{(DW-16){1'b0}}, 16'(len)};
    a = a + 1'b1;
    nw = (len > MAXB) ? 0 : (len + 31) / 32;
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
      mem[a] = d;
      if (queue_it) sb.push_back({d, w == 0, w == nw - 1, (w == nw - 1) ? 5'(len) : 5'd0});
      a = a + 1'b1;
    end
    a_out = a;
  endtask

  task automatic start_run(input logic [AW-1:0] b, input logic [15:0] c);
    @(posedge clk);
    #1 base_addr = b;
    pkt_cnt = c;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, err_len, bus.rx_valid, bus.rx_sop, bus.rx_eop} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b required 000000", {busy, done, err_len, bus.rx_valid, bus.rx_sop, bus.rx_eop});
    end
    n_cmp++;
    if (bus.rx_mod !== 5'd0 || bus.rx_data !== '0) begin
      n_err++;
      $display("FAIL reset_stream: got mod=%0d data=%h required 0", bus.rx_mod, bus.rx_data);
    end
    n_cmp++;
    if ({bus.mem_en_b, bus.mem_we_b} !== 2'b00 || bus.mem_addr_b !== '0) begin
      n_err++;
      $display("FAIL reset_mem: got en=%b we=%b addr=%h required 0", bus.mem_en_b, bus.mem_we_b, bus.mem_addr_b);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || bus.mem_en_b !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got busy=%b en=%b required 0", busy, bus.mem_en_b);
    end
  endtask

  task automatic test_list();
    logic [AW-1:0] a;
    bit ok;
    put_pkt(11'h010, 64, 1'b1, a);
    put_pkt(a, 33, 1'b1, a);
    put_pkt(a, 0, 1'b0, a);
    start_run(11'h010, LOOP ? 16'd2 : 16'd0);
    repeat (3) @(posedge clk);
    #1 base_addr = 11'h300;
    start = 1'b1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL list_busy: got %b required 1", busy);
    end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(300, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL list_done: got no done pulse required done within 300 clocks");
    end
    n_cmp++;
    if (busy !== 1'b0 || err_len !== 1'b0) begin
      n_err++;
      $display("FAIL list_end_state: got busy=%b err_len=%b required 0 0", busy, err_len);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL list_drain: got %0d words outstanding required 0", sb.size());
    end
  endtask

  task automatic test_single();
    logic [AW-1:0] a;
    bit ok;
    put_pkt(11'h100, 20, 1'b1, a);
    put_pkt(a, 0, 1'b0, a);
    start_run(11'h100, 16'd1);
    wait_done(200, ok);
    n_cmp++;
    if (!ok || sb.size() != 0) begin
      n_err++;
      $display("FAIL single: got done=%b outstanding=%0d required 1 0", ok, sb.size());
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a;
    bit ok;
    int p0;
    put_pkt(11'h200, 128, 1'b1, a);
    put_pkt(a, 0, 1'b0, a);
    max_fill = 0;
    p0 = n_pop;
    start_run(11'h200, LOOP ? 16'd1 : 16'd0);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1 rdy = ~rdy;
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    rdy = 1'b1;
    n_cmp++;
    if (!ok || n_pop - p0 != 4) begin
      n_err++;
      $display("FAIL bp_words: got done=%b words=%0d required 1 4", ok, n_pop - p0);
    end
    n_cmp++;
    if (max_fill > FD) begin
      n_err++;
      $display("FAIL bp_fifo_fill: got %0d required <= %0d", max_fill, FD);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a;
    logic [AW-1:0] exp_a [5];
    bit ok;
    exp_a = '{11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h002};
    put_pkt(11'h7FE, 96, 1'b1, a);
    put_pkt(a, 0, 1'b0, a);
    rd_addrs.delete();
    start_run(11'h7FE, LOOP ? 16'd1 : 16'd0);
    wait_done(200, ok);
    n_cmp++;
    if (!ok || sb.size() != 0) begin
      n_err++;
      $display("FAIL wrap_done: got done=%b outstanding=%0d required 1 0", ok, sb.size());
    end
    n_cmp++;
    if (rd_addrs.size() != (LOOP ? 4 : 5)) begin
      n_err++;
      $display("FAIL wrap_reads: got %0d reads required %0d", rd_addrs.size(), LOOP ? 4 : 5);
    end
    for (int i = 0; i < rd_addrs.size() && i < 5; i++) begin
      n_cmp++;
      if (rd_addrs[i] !== exp_a[i]) begin
        n_err++;
        $display("FAIL wrap_addr%0d: got %h required %h", i, rd_addrs[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_err();
    logic [AW-1:0] a;
    bit ok;
    int p0;
    put_pkt(11'h300, 10000, 1'b0, a);
    p0 = n_pop;
    start_run(11'h300, 16'd0);
    wait_done(200, ok);
    n_cmp++;
    if (!ok || err_len !== 1'b1) begin
      n_err++;
      $display("FAIL err_len_set: got done=%b err_len=%b required 1 1", ok, err_len);
    end
    n_cmp++;
    if (n_pop != p0) begin
      n_err++;
      $display("FAIL err_no_words: got %0d words required 0", n_pop - p0);
    end
    put_pkt(11'h320, 20, 1'b1, a);
    put_pkt(a, 0, 1'b0, a);
    start_run(11'h320, 16'd1);
    @(negedge clk);
    n_cmp++;
    if (err_len !== 1'b0) begin
      n_err++;
      $display("FAIL err_len_clear: got %b required 0", err_len);
    end
    wait_done(200, ok);
    n_cmp++;
    if (!ok || sb.size() != 0) begin
      n_err++;
      $display("FAIL err_rerun: got done=%b outstanding=%0d required 1 0", ok, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a;
    bit ok;
    int p0;
    put_pkt(11'h400, 256, 1'b1, a);
    put_pkt(a, 0, 1'b0, a);
    p0 = n_pop;
    start_run(11'h400, LOOP ? 16'd1 : 16'd0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_pop - p0 >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL mid_progress: got %0d words required >= 3", n_pop - p0);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.rx_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_drop: got valid=%b busy=%b required 0 0", bus.rx_valid, busy);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    put_pkt(11'h400, 256, 1'b1, a);
    start_run(11'h400, LOOP ? 16'd1 : 16'd0);
    wait_done(300, ok);
    n_cmp++;
    if (!ok || sb.size() != 0) begin
      n_err++;
      $display("FAIL mid_replay: got done=%b outstanding=%0d required 1 0", ok, sb.size());
    end
  endtask

`ifdef RX_PKT_GEN_LOOP_EN
  task automatic test_loop();
    logic [AW-1:0] a;
    bit ok;
    int s0, n;
    s0 = sb.size();
    put_pkt(11'h500, 64, 1'b1, a);
    put_pkt(a, 0, 1'b0, a);
    n = sb.size() - s0;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < n; k++) sb.push_back(sb[s0 + k]);
    start_run(11'h500, 16'd3);
    wait_done(400, ok);
    n_cmp++;
    if (!ok || sb.size() != 0) begin
      n_err++;
      $display("FAIL loop: got done=%b outstanding=%0d required 1 0", ok, sb.size());
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    test_reset();
    test_list();
    test_single();
    test_backpressure();
    test_wrap();
    test_err();
    test_reset_mid();
`ifdef RX_PKT_GEN_LOOP_EN
    test_loop();
`endif
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
